// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: runs one address+data transaction on the multiplexed RTC bus
// (CS/AD/WR/RD plus an 8-bit shared address/data bus) with clock-count timing.
// Optional feature macro: RTC_SAMPLE_CHECK_EN adds a mid-strobe read sample whose
// disagreement with the final sample is reported on rd_err.
module rtc_bus_cycle #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 4,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rd_nwr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       CS,
  output logic       AD,
  output logic       WR,
  output logic       RD,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rd_err
);

  localparam int unsigned DW = 8;
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SET, S_A_STB, S_A_HOLD, S_GAP,
    S_D_SET, S_D_STB, S_D_HOLD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_rd_q;
  logic [DW-1:0]     req_addr_q, req_wdata_q;
  logic              accept;
  logic              last_stb;

  logic              cs_d, ad_d, wr_d, rd_d, oe_d, busy_d, done_d;
  logic [DW-1:0]     bus_out_d, rdata_d;

  // A request is taken only when both the FSM and the visible busy flag are idle
  assign accept   = (state_q == S_IDLE) && start && !busy;
  assign last_stb = (state_q == S_D_STB) && (cnt_q == '0);

  // State and phase-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each timed state loads its count on entry and leaves when it hits zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = S_A_SET;
          cnt_d   = LD_SETUP;
        end
      end
      S_A_SET:  if (cnt_q == '0) begin state_d = S_A_STB;  cnt_d = LD_PULSE; end
      S_A_STB:  if (cnt_q == '0) begin state_d = S_A_HOLD; cnt_d = LD_HOLD;  end
      S_A_HOLD: if (cnt_q == '0) begin state_d = S_GAP;    cnt_d = LD_GAP;   end
      S_GAP:    if (cnt_q == '0) begin state_d = S_D_SET;  cnt_d = LD_SETUP; end
      S_D_SET:  if (cnt_q == '0) begin state_d = S_D_STB;  cnt_d = LD_PULSE; end
      S_D_STB:  if (cnt_q == '0) begin state_d = S_D_HOLD; cnt_d = LD_HOLD;  end
      S_D_HOLD: if (cnt_q == '0) begin state_d = S_DONE;   cnt_d = '0;       end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch: direction, address and write data captured on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      req_rd_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (accept) begin
      req_rd_q    <= rd_nwr;
      req_addr_q  <= addr;
      req_wdata_q <= wdata;
    end
  end

  // Bus levels decoded from the current phase; read data taken on the last strobe clock
  always_comb begin
    cs_d      = 1'b1;
    ad_d      = 1'b1;
    wr_d      = 1'b1;
    rd_d      = 1'b1;
    oe_d      = 1'b0;
    bus_out_d = '0;
    busy_d    = (state_q != S_IDLE);
    done_d    = 1'b0;
    rdata_d   = rdata;
    case (state_q)
      S_A_SET, S_A_HOLD: begin
        cs_d      = 1'b0;
        ad_d      = 1'b0;
        oe_d      = 1'b1;
        bus_out_d = req_addr_q;
      end
      S_A_STB: begin
        cs_d      = 1'b0;
        ad_d      = 1'b0;
        oe_d      = 1'b1;
        bus_out_d = req_addr_q;
        wr_d      = 1'b0;
      end
      S_D_SET, S_D_HOLD: begin
        cs_d      = 1'b0;
        oe_d      = !req_rd_q;
        bus_out_d = req_rd_q ? '0 : req_wdata_q;
      end
      S_D_STB: begin
        cs_d      = 1'b0;
        oe_d      = !req_rd_q;
        bus_out_d = req_rd_q ? '0 : req_wdata_q;
        wr_d      = req_rd_q;
        rd_d      = !req_rd_q;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    if (last_stb && req_rd_q) rdata_d = bus_in;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      CS      <= 1'b1;
      AD      <= 1'b1;
      WR      <= 1'b1;
      RD      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      CS      <= cs_d;
      AD      <= ad_d;
      WR      <= wr_d;
      RD      <= rd_d;
      bus_oe  <= oe_d;
      bus_out <= bus_out_d;
      busy    <= busy_d;
      done    <= done_d;
      rdata   <= rdata_d;
    end
  end

`ifdef RTC_SAMPLE_CHECK_EN
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(T_PULSE / 2);
  logic [DW-1:0] mid_q;

  // Mid-strobe sample, compared with the final sample when a read completes
  always_ff @(posedge clk) begin
    if (reset) begin
      mid_q  <= '0;
      rd_err <= 1'b0;
    end else begin
      if ((state_q == S_D_STB) && (cnt_q == MID_CNT) && req_rd_q) mid_q <= bus_in;
      if ((state_q == S_DONE) && req_rd_q) rd_err <= (mid_q != rdata);
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb_rtc_bus_cycle: directed and random RTC bus transactions checked against a
// cycle-counting model of the bus protocol and a read-data/rd_err model.
module tb_rtc_bus_cycle;

  localparam int T_SETUP = 2;
  localparam int T_PULSE = 10;
  localparam int T_HOLD  = 2;
  localparam int T_GAP   = 4;
  localparam int PHASE   = T_SETUP + T_PULSE + T_HOLD;
  localparam int LAT     = 2 * PHASE + T_GAP + 1;
`ifdef RTC_SAMPLE_CHECK_EN
  localparam bit SAMPLE_CHK = 1'b1;
`else
  localparam bit SAMPLE_CHK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic       rd_nwr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       CS;
  logic       AD;
  logic       WR;
  logic       RD;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rd_err;

  int         checks;
  int         errors;
  logic [7:0] m_rdata;
  logic       m_err;

  rtc_bus_cycle #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rd_nwr(rd_nwr), .addr(addr),
    .wdata(wdata), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .CS(CS), .AD(AD), .WR(WR), .RD(RD), .busy(busy), .done(done),
    .rdata(rdata), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: drives start, plays the RTC device on bus_in while RD is low,
  // tallies protocol observations cycle by cycle and compares them with the model.
  task automatic run_txn(input logic rd, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] v1, input logic [7:0] v2, input bit glitch,
                         input bit repulse, input int rst_at);
    int last, done_n, ndone, busy_n, cs_lo, ad_lo;
    int wr_a, wr_dt, wr_any, rd_lo, rd_any, bad, rdlow;
    logic [7:0] rdata_at_done, exp_rdata;
    logic       err_at_done, exp_err;
    last = 60; done_n = -1; ndone = 0; busy_n = 0; cs_lo = 0; ad_lo = 0;
    wr_a = 0; wr_dt = 0; wr_any = 0; rd_lo = 0; rd_any = 0; bad = 0; rdlow = 0;
    rdata_at_done = '0; err_at_done = 1'b0;

    if (rst_at >= 0) begin
      exp_rdata = 8'h00;
      exp_err   = 1'b0;
    end else if (rd) begin
      exp_rdata = glitch ? v2 : v1;
      exp_err   = SAMPLE_CHK && glitch && (v1 != v2);
    end else begin
      exp_rdata = m_rdata;
      exp_err   = m_err;
    end

    start = 1'b1; rd_nwr = rd; addr = a; wdata = w;
    @(posedge clk);
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      start  = repulse && (n == 5 || n == 20);
      rd_nwr = 1'($urandom);
      addr   = 8'($urandom);
      wdata  = 8'($urandom);

      if (done === 1'b1) begin
        ndone++;
        if (done_n < 0) begin
          done_n = n;
          last = n + 1;
          rdata_at_done = rdata;
          err_at_done = rd_err;
        end
      end
      if (busy === 1'b1) busy_n++;
      if (CS === 1'b0) cs_lo++;
      if (AD === 1'b0) ad_lo++;
      if (WR === 1'b0) wr_any++;
      if (RD === 1'b0) rd_any++;
      if (WR === 1'b0 && AD === 1'b0 && CS === 1'b0 && bus_oe === 1'b1 && bus_out === a) wr_a++;
      if (WR === 1'b0 && AD === 1'b1 && CS === 1'b0 && bus_oe === 1'b1 && bus_out === w) wr_dt++;
      if (RD === 1'b0 && AD === 1'b1 && CS === 1'b0 && bus_oe === 1'b0) rd_lo++;
      if ((RD === 1'b0 && WR === 1'b0) || (RD === 1'b0 && bus_oe !== 1'b0)) bad++;

      if (rst_at >= 0 && n == rst_at + 1) begin
        chk("rst_CS", CS, 1); chk("rst_WR", WR, 1); chk("rst_RD", RD, 1);
        chk("rst_AD", AD, 1); chk("rst_oe", bus_oe, 0); chk("rst_busy", busy, 0);
        reset = 1'b0;
      end
      if (n == rst_at) reset = 1'b1;

      if (RD === 1'b0) begin
        rdlow++;
        bus_in = (glitch && rdlow > 7) ? v2 : v1;
      end else begin
        rdlow = 0;
        bus_in = 8'($urandom);
      end
    end

    if (rst_at < 0) begin
      chk("latency", done_n, LAT);
      chk("done_count", ndone, 1);
      chk("busy_cycles", busy_n, LAT);
      chk("cs_low_cycles", cs_lo, 2 * PHASE);
      chk("ad_low_cycles", ad_lo, PHASE);
      chk("addr_wr_cycles", wr_a, T_PULSE);
      chk("wr_low_total", wr_any, rd ? T_PULSE : 2 * T_PULSE);
      chk("rd_low_total", rd_any, rd ? T_PULSE : 0);
      chk("data_strobe_cycles", rd ? rd_lo : wr_dt, T_PULSE);
      chk("strobe_overlap", bad, 0);
      chk("rdata_at_done", rdata_at_done, exp_rdata);
      chk("rd_err_at_done", err_at_done, exp_err);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
    end else begin
      chk("no_done_after_reset", ndone, 0);
      chk("rdata_after_reset", rdata, exp_rdata);
      chk("rd_err_after_reset", rd_err, exp_err);
    end
    m_rdata = exp_rdata;
    m_err   = exp_err;
  endtask

  initial begin
    checks = 0; errors = 0; m_rdata = 8'h00; m_err = 1'b0;
    reset = 1'b1; start = 1'b0; rd_nwr = 1'b0; addr = '0; wdata = '0; bus_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_CS", CS, 1); chk("reset_AD", AD, 1); chk("reset_WR", WR, 1);
    chk("reset_RD", RD, 1); chk("reset_oe", bus_oe, 0); chk("reset_bus_out", bus_out, 0);
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_rdata", rdata, 0);
    chk("reset_rd_err", rd_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: write, read, back-to-back read, ignored re-start, reset mid data strobe
    run_txn(1'b0, 8'h21, 8'h45, 8'h00, 8'h00, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);
    run_txn(1'b1, 8'h22, 8'h00, 8'h37, 8'h37, 1'b0, 1'b0, -1);
    run_txn(1'b1, 8'h22, 8'h00, 8'h12, 8'h12, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);
    run_txn(1'b0, 8'h30, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, -1);
    repeat (2) @(negedge clk);
    run_txn(1'b0, 8'h31, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 24);
    repeat (2) @(negedge clk);

    // Read whose bus value moves after the mid-strobe sample, then a stable repeat
    run_txn(1'b1, 8'h22, 8'h00, 8'h37, 8'h38, 1'b1, 1'b0, -1);
    run_txn(1'b1, 8'h22, 8'h00, 8'h38, 8'h38, 1'b0, 1'b0, -1);

    // Random transactions with random idle gaps (zero gap = back-to-back)
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
